// File: rtl/captura_teclado_hex.sv
// 4x4 matrix keypad scanner: synchronizes and debounces the rows, decodes each
// accepted press to a hex digit and shifts it into a 16-bit display register.
module captura_teclado_hex #(
  parameter int SCAN_DIV       = 10000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [3:0]  fila_i,
  input  logic        borrar_i,
  output logic [3:0]  col_o,
  output logic [15:0] dato_o,
  output logic [3:0]  codigo_o,
  output logic        tecla_valida_o
);

  localparam int              CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [3:0]      DB_N    = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ESCANEO    = 2'd0,
    REBOTE     = 2'd1,
    PRESIONADA = 2'd2
  } estado_t;

  estado_t       estado_q;
  logic [3:0]    sync1_q;
  logic [3:0]    fs_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [3:0]    col_q;
  logic [3:0]    fila_lat_q;
  logic [3:0]    cnt_db_q;
  logic [15:0]   dato_q;
  logic [3:0]    codigo_q;
  logic          valida_q;

  logic          m;
  logic          muestra_valida;
  logic [1:0]    fila_idx;
  logic [1:0]    col_idx;
  logic [3:0]    codigo_d;
  logic [3:0]    cnt_db_inc;

  function automatic logic una_baja(input logic [3:0] v);
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: una_baja = 1'b1;
      default:                            una_baja = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] indice_bajo(input logic [3:0] v);
    case (v)
      4'b1101: indice_bajo = 2'd1;
      4'b1011: indice_bajo = 2'd2;
      4'b0111: indice_bajo = 2'd3;
      default: indice_bajo = 2'd0;
    endcase
  endfunction

  // Star position yields E and hash yields F on the bottom row.
  function automatic logic [3:0] tecla_hex(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: tecla_hex = 4'h1;
      4'b00_01: tecla_hex = 4'h2;
      4'b00_10: tecla_hex = 4'h3;
      4'b00_11: tecla_hex = 4'hA;
      4'b01_00: tecla_hex = 4'h4;
      4'b01_01: tecla_hex = 4'h5;
      4'b01_10: tecla_hex = 4'h6;
      4'b01_11: tecla_hex = 4'hB;
      4'b10_00: tecla_hex = 4'h7;
      4'b10_01: tecla_hex = 4'h8;
      4'b10_10: tecla_hex = 4'h9;
      4'b10_11: tecla_hex = 4'hC;
      4'b11_00: tecla_hex = 4'hE;
      4'b11_01: tecla_hex = 4'h0;
      4'b11_10: tecla_hex = 4'hF;
      default:  tecla_hex = 4'hD;
    endcase
  endfunction

  always_comb begin
    m              = (cnt_q == CNT_MAX);
    cnt_d          = m ? '0 : cnt_q + 1'b1;
    muestra_valida = una_baja(fs_q);
    fila_idx       = indice_bajo(fila_lat_q);
    col_idx        = indice_bajo(col_q);
    codigo_d       = tecla_hex(fila_idx, col_idx);
    cnt_db_inc     = cnt_db_q + 4'd1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q <= 4'b1111;
      fs_q    <= 4'b1111;
      cnt_q   <= '0;
    end else begin
      sync1_q <= fila_i;
      fs_q    <= sync1_q;
      cnt_q   <= cnt_d;
    end
  end

  // Sampling FSM; the column only moves on a sample event m.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      estado_q   <= ESCANEO;
      col_q      <= 4'b1110;
      fila_lat_q <= 4'b1111;
      cnt_db_q   <= 4'd0;
      dato_q     <= 16'h0000;
      codigo_q   <= 4'h0;
      valida_q   <= 1'b0;
    end else begin
      valida_q <= 1'b0;
      if (borrar_i) dato_q <= 16'h0000;
      case (estado_q)
        ESCANEO: begin
          if (m) begin
            if (muestra_valida) begin
              fila_lat_q <= fs_q;
              cnt_db_q   <= 4'd1;
              estado_q   <= REBOTE;
            end else begin
              col_q <= {col_q[2:0], col_q[3]};
            end
          end
        end
        REBOTE: begin
          if (m) begin
            if (muestra_valida && (fs_q == fila_lat_q)) begin
              if (cnt_db_inc == DB_N) begin
                codigo_q <= codigo_d;
                dato_q   <= borrar_i ? {12'h000, codigo_d} : {dato_q[11:0], codigo_d};
                valida_q <= 1'b1;
                cnt_db_q <= 4'd0;
                estado_q <= PRESIONADA;
              end else begin
                cnt_db_q <= cnt_db_inc;
              end
            end else begin
              cnt_db_q <= 4'd0;
              col_q    <= {col_q[2:0], col_q[3]};
              estado_q <= ESCANEO;
            end
          end
        end
        PRESIONADA: begin
          if (m) begin
            if (fs_q == 4'b1111) begin
              if (cnt_db_inc == DB_N) begin
                cnt_db_q <= 4'd0;
                col_q    <= {col_q[2:0], col_q[3]};
                estado_q <= ESCANEO;
              end else begin
                cnt_db_q <= cnt_db_inc;
              end
            end else begin
              cnt_db_q <= 4'd0;
            end
          end
        end
        default: begin
          cnt_db_q <= 4'd0;
          estado_q <= ESCANEO;
        end
      endcase
    end
  end

  assign col_o          = col_q;
  assign dato_o         = dato_q;
  assign codigo_o       = codigo_q;
  assign tecla_valida_o = valida_q;

endmodule

// File: tb/tb_captura_teclado_hex.sv
// Bench for captura_teclado_hex with a behavioural keypad: pressed keys pull
// their row low whenever the DUT drives their column low.
module tb_captura_teclado_hex;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  fila;
  logic        borrar = 1'b0;
  logic [3:0]  col;
  logic [15:0] dato;
  logic [3:0]  codigo;
  logic        valida;

  logic [15:0] pressed = 16'h0000;
  logic [19:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          pulse_cnt = 0;
  logic        prev_valida = 1'b0;

  captura_teclado_hex #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk_i          (clk),
    .reset_n_i      (rst_n),
    .fila_i         (fila),
    .borrar_i       (borrar),
    .col_o          (col),
    .dato_o         (dato),
    .codigo_o       (codigo),
    .tecla_valida_o (valida)
  );

  always #5 clk = ~clk;

  always_comb begin
    fila = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) fila[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every pulse must match the oldest expected {code, dato}.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valida <= 1'b0;
    end else begin
      if (valida) begin
        pulse_cnt++;
        checks++;
        if (prev_valida) begin
          failures++;
          $display("FAIL double_pulse: valid high on consecutive cycles");
        end else if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse: code %0h dato %0h", codigo, dato);
        end else begin
          logic [19:0] e;
          e = exp_q.pop_front();
          if ({codigo, dato} !== e) begin
            failures++;
            $display("FAIL accept: got code %0h dato %0h expected code %0h dato %0h",
                     codigo, dato, e[19:16], e[15:0]);
          end
        end
      end
      prev_valida <= valida;
    end
  end

  task automatic wait_pulse(input int start);
    int n = 0;
    while (pulse_cnt == start && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (pulse_cnt == start) begin
      checks++;
      failures++;
      $display("FAIL pulse_timeout: no accept within 100 cycles");
    end
  endtask

  // Leaves the bench at the first negedge of a fresh column-0 slot.
  task automatic wait_col0_fresh();
    int n = 0;
    while (col == 4'b1110 && n < 40) begin @(negedge clk); n++; end
    while (col != 4'b1110 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) begin
      checks++;
      failures++;
      $display("FAIL col_timeout: column 1110 not reached, col %b", col);
    end
  endtask

  task automatic tap(input int r, input int c, input logic [3:0] code, input logic [15:0] d);
    int pc;
    pc = pulse_cnt;
    exp_q.push_back({code, d});
    pressed[r*4+c] = 1'b1;
    wait_pulse(pc);
    repeat (4) @(negedge clk);
    pressed[r*4+c] = 1'b0;
    repeat (30) @(negedge clk);
  endtask

  task automatic clear_dato();
    @(negedge clk);
    borrar = 1'b1;
    @(negedge clk);
    borrar = 1'b0;
  endtask

  initial begin
    int pc;
    logic [3:0] exp_col;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_col", 32'(col), 32'h0E);
    check("rst_dato", 32'(dato), 32'h0);
    check("rst_codigo", 32'(codigo), 32'h0);
    check("rst_valid", 32'(valida), 32'h0);
    rst_n = 1'b1;
    #1;
    exp_col = 4'b1110;
    for (int k = 0; k < 5; k++) begin
      check("scan_col", 32'(col), 32'(exp_col));
      exp_col = {exp_col[2:0], exp_col[3]};
      repeat (4) @(negedge clk);
    end
    check("scan_dato", 32'(dato), 32'h0);

    // Clean hold of (r1,c2): one pulse, column held until released 3 samples
    pc = pulse_cnt;
    exp_q.push_back({4'h6, 16'h0006});
    pressed[1*4+2] = 1'b1;
    wait_pulse(pc);
    repeat (5) @(negedge clk);
    check("hold_col", 32'(col), 32'h0B);
    repeat (20) @(negedge clk);
    check("hold_col_long", 32'(col), 32'h0B);
    pressed[1*4+2] = 1'b0;
    repeat (10) @(negedge clk);
    check("release_col_held", 32'(col), 32'h0B);
    repeat (6) @(negedge clk);
    checks++;
    if (col == 4'b1011) begin
      failures++;
      $display("FAIL release_resume: col still %b expected rotation", col);
    end
    repeat (10) @(negedge clk);

    // borrar clears dato only
    clear_dato();
    check("borrar_dato", 32'(dato), 32'h0);
    check("borrar_codigo", 32'(codigo), 32'h6);

    // Sequence with wrap
    tap(0, 0, 4'h1, 16'h0001);
    tap(0, 3, 4'hA, 16'h001A);
    tap(0, 2, 4'h3, 16'h01A3);
    tap(3, 2, 4'hF, 16'h1A3F);
    tap(3, 1, 4'h0, 16'hA3F0);
    check("seq_dato", 32'(dato), 32'hA3F0);

    // Bounce: one low sample at c0, then high
    for (int k = 0; k < 3; k++) begin
      wait_col0_fresh();
      pressed[0] = 1'b1;
      repeat (4) @(negedge clk);
      pressed[0] = 1'b0;
      repeat (12) @(negedge clk);
    end
    check("bounce_dato", 32'(dato), 32'hA3F0);
    exp_col = col;
    repeat (8) @(negedge clk);
    checks++;
    if (col == exp_col) begin
      failures++;
      $display("FAIL bounce_scan: col stuck at %b", col);
    end

    // Ghosting: r0 and r2 at c1, then r2 released
    pressed[0*4+1] = 1'b1;
    pressed[2*4+1] = 1'b1;
    repeat (60) @(negedge clk);
    check("ghost_dato", 32'(dato), 32'hA3F0);
    pc = pulse_cnt;
    exp_q.push_back({4'h2, 16'h3F02});
    pressed[2*4+1] = 1'b0;
    wait_pulse(pc);
    pressed = 16'h0000;
    repeat (30) @(negedge clk);

    // borrar coinciding with the accept of key 7
    clear_dato();
    tap(0, 0, 4'h1, 16'h0001);
    tap(0, 1, 4'h2, 16'h0012);
    tap(0, 2, 4'h3, 16'h0123);
    tap(1, 0, 4'h4, 16'h1234);
    wait_col0_fresh();
    pc = pulse_cnt;
    exp_q.push_back({4'h7, 16'h0007});
    pressed[2*4+0] = 1'b1;
    repeat (11) @(negedge clk);
    borrar = 1'b1;
    @(negedge clk);
    borrar = 1'b0;
    wait_pulse(pc);
    pressed = 16'h0000;
    repeat (30) @(negedge clk);
    check("borrar_accept_dato", 32'(dato), 32'h0007);

    // Reset while in REBOTE, key kept held through reset
    wait_col0_fresh();
    pressed[0] = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_col", 32'(col), 32'h0E);
    check("midrst_dato", 32'(dato), 32'h0);
    check("midrst_codigo", 32'(codigo), 32'h0);
    check("midrst_valid", 32'(valida), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pc = pulse_cnt;
    repeat (8) @(negedge clk);
    check("midrst_no_early", 32'(pulse_cnt - pc), 32'h0);
    exp_q.push_back({4'h1, 16'h0001});
    wait_pulse(pc);
    pressed = 16'h0000;
    repeat (30) @(negedge clk);

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
